// File: rtl/prog_fetch_sequencer_if.sv
// prog_fetch_sequencer_if: load-stream and memory-port bundle for prog_fetch_sequencer
//   load_valid/load_data/load_last/load_ready : program word stream into the sequencer
//   mem_addr/mem_data_in/mem_wren/mem_enable/mem_acc_size : memory request side
//   mem_insn : memory read data, valid one cycle after the address is presented
//   master = sequencer side, slave = stream source / memory side
interface prog_fetch_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              load_valid;
  logic [0:DATA_W-1] load_data;
  logic              load_last;
  logic              load_ready;
  logic [0:ADDR_W-1] mem_addr;
  logic [0:DATA_W-1] mem_data_in;
  logic              mem_wren;
  logic              mem_enable;
  logic [0:1]        mem_acc_size;
  logic [0:DATA_W-1] mem_insn;
  modport master (
    input  load_valid, load_data, load_last, mem_insn,
    output load_ready, mem_addr, mem_data_in, mem_wren, mem_enable, mem_acc_size
  );
  modport slave (
    output load_valid, load_data, load_last, mem_insn,
    input  load_ready, mem_addr, mem_data_in, mem_wren, mem_enable, mem_acc_size
  );
endinterface

// File: rtl/prog_fetch_sequencer.sv
// prog_fetch_sequencer: loads a program into memory, then fetches it in order down a pc delay chain
//   clk, rst          : clock, synchronous active-high reset
//   bus               : load stream + memory port (master side)
//   start_i, stall_i  : begin/re-run fetch, freeze fetch pipeline
//   insn_out_o, insn_valid_o, pc_stage_o, valid_stage_o : fetched word and aligned pc chain
//   word_count_o, busy_o, done_o, overflow_o            : status
module prog_fetch_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [0:ADDR_W-1] START_ADDRESS = 32'h80020000,
  parameter int MAX_WORDS = 1024,
  parameter int PIPE_DEPTH = 2,
  localparam int WC_W = $clog2(MAX_WORDS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  prog_fetch_sequencer_if.master       bus,
  input  logic                         start_i,
  input  logic                         stall_i,
  output logic [0:DATA_W-1]            insn_out_o,
  output logic                         insn_valid_o,
  output logic [0:PIPE_DEPTH*ADDR_W-1] pc_stage_o,
  output logic [0:PIPE_DEPTH-1]        valid_stage_o,
  output logic [0:WC_W-1]              word_count_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         overflow_o
);
  typedef enum logic [2:0] {LOAD, WAIT, FETCH, DRAIN, DONE} state_t;
  state_t            state_q;
  logic [0:WC_W-1]   wc_q, ic_q;
  logic              tag1_q, tag2_q, sp_q, ovf_q;
  logic [0:ADDR_W-1] a2_q;
  logic [0:DATA_W-1] buf_q, insn_q;
  logic [0:ADDR_W-1] pc_q [PIPE_DEPTH];
  logic [0:PIPE_DEPTH-1] v_q;
  logic accept, kick, fetching, run, empty;
  assign accept   = state_q == LOAD && bus.load_valid && bus.load_ready;
  // start in LOAD is honoured only before any word arrives, so an empty program can reach DONE
  assign kick     = start_i && (state_q == WAIT || state_q == DONE || (state_q == LOAD && wc_q == '0));
  assign fetching = state_q == FETCH || state_q == DRAIN;
  assign run      = fetching && !stall_i;
  assign empty    = !tag1_q && !tag2_q && v_q == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= LOAD;
      bus.load_ready   <= 1'b1;
      bus.mem_wren     <= 1'b0;
      bus.mem_addr     <= START_ADDRESS;
      bus.mem_data_in  <= '0;
      wc_q             <= '0;
      ic_q             <= '0;
      tag1_q           <= 1'b0;
      tag2_q           <= 1'b0;
      sp_q             <= 1'b0;
      ovf_q            <= 1'b0;
      a2_q             <= '0;
      buf_q            <= '0;
      insn_q           <= '0;
      v_q              <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) pc_q[k] <= '0;
    end else begin
      bus.mem_wren <= accept && !kick;
      sp_q         <= fetching && stall_i;
      // the held address keeps re-reading the next word, so the word owed to a2 is parked here
      if (fetching && stall_i && !sp_q) buf_q <= bus.mem_insn;
      if (kick) begin
        bus.load_ready <= 1'b0;
        state_q        <= wc_q == '0 ? DONE : (wc_q == WC_W'(1) ? DRAIN : FETCH);
        if (wc_q != '0) begin
          bus.mem_addr <= START_ADDRESS;
          ic_q         <= WC_W'(1);
          tag1_q       <= 1'b1;
        end
      end else if (accept) begin
        bus.mem_addr    <= START_ADDRESS + ADDR_W'({wc_q, 2'b00});
        bus.mem_data_in <= bus.load_data;
        wc_q            <= wc_q + WC_W'(1);
        if (bus.load_last || wc_q + WC_W'(1) == WC_W'(MAX_WORDS)) begin
          state_q        <= WAIT;
          bus.load_ready <= 1'b0;
          ovf_q          <= ovf_q | !bus.load_last;
        end
      end else if (run) begin
        if (state_q == FETCH) begin
          bus.mem_addr <= START_ADDRESS + ADDR_W'({ic_q, 2'b00});
          ic_q         <= ic_q + WC_W'(1);
          if (ic_q + WC_W'(1) == wc_q) state_q <= DRAIN;
        end else if (empty) state_q <= DONE;
        tag1_q   <= state_q == FETCH;
        tag2_q   <= tag1_q;
        a2_q     <= bus.mem_addr;
        insn_q   <= sp_q ? buf_q : bus.mem_insn;
        v_q      <= v_q >> 1;
        v_q[0]   <= tag2_q;
        pc_q[0]  <= a2_q;
        for (int k = 1; k < PIPE_DEPTH; k++) pc_q[k] <= pc_q[k-1];
      end
    end
  end
  for (genvar g = 0; g < PIPE_DEPTH; g++) assign pc_stage_o[g*ADDR_W +: ADDR_W] = pc_q[g];
  assign bus.mem_enable   = 1'b1;
  assign bus.mem_acc_size = 2'b00;
  assign insn_out_o       = insn_q;
  assign insn_valid_o     = v_q[0];
  assign valid_stage_o    = v_q;
  assign word_count_o     = wc_q;
  assign busy_o           = state_q == LOAD || fetching;
  assign done_o           = state_q == DONE;
  assign overflow_o       = ovf_q;
endmodule
